// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a small receive FIFO.
// CPU-visible DATA/STATUS/CTRL registers on the peripheral bus.
module uart_rx #(
  parameter int DIVISOR = 104,
  parameter int DEPTH   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] addr,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rx,
  output logic       rx_avail
);

  localparam int CW = $clog2(DIVISOR);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  localparam logic [CW-1:0] HALF = CW'(DIVISOR / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(DIVISOR - 1);
  localparam logic [NW-1:0] NFULL = NW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic sync1_q, sync2_q;
  logic rx_s, expire;
  logic push_req, frm_set;

  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic ovr_q, ovr_d, fe_q, fe_d, en_q, en_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic rd_valid_q, avail_q;
  logic pop, push, ovr_set, sts_wr;
  logic [7:0] status;
  logic unused_wr;

  assign rx_s = sync2_q;
  assign expire = (tick_q == '0);
  assign unused_wr = ^{wr_data[7:4], wr_data[1]};

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    push_req = 1'b0;
    frm_set  = 1'b0;
    if (!en_q) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            tick_d  = HALF;
            state_d = S_START;
          end
        end
        S_START: begin
          if (!expire) begin
            tick_d = tick_q - 1'b1;
          end else if (!rx_s) begin
            tick_d  = FULL;
            bit_d   = 3'd0;
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_DATA: begin
          if (!expire) begin
            tick_d = tick_q - 1'b1;
          end else begin
            shift_d = {rx_s, shift_q[7:1]};
            tick_d  = FULL;
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = S_STOP;
          end
        end
        S_STOP: begin
          if (!expire) begin
            tick_d = tick_q - 1'b1;
          end else if (rx_s) begin
            push_req = 1'b1;
            state_d  = S_IDLE;
          end else begin
            frm_set = 1'b1;
            state_d = S_BREAK;
          end
        end
        S_BREAK: begin
          if (rx_s) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Pop is resolved first so a full FIFO can accept a same-cycle push.
  always_comb begin
    pop     = rd_en && (addr == 2'd0) && (cnt_q != '0);
    push    = push_req && ((cnt_q != NFULL) || pop);
    ovr_set = push_req && !push;
    sts_wr  = wr_en && (addr == 2'd1);
    cnt_d   = cnt_q + NW'(push) - NW'(pop);
    wp_d    = push ? wp_q + 1'b1 : wp_q;
    rp_d    = pop ? rp_q + 1'b1 : rp_q;
    ovr_d   = ovr_q;
    if (ovr_set) ovr_d = 1'b1;
    else if (sts_wr && wr_data[2]) ovr_d = 1'b0;
    fe_d = fe_q;
    if (frm_set) fe_d = 1'b1;
    else if (sts_wr && wr_data[3]) fe_d = 1'b0;
    en_d = en_q;
    if (wr_en && (addr == 2'd2)) en_d = wr_data[0];
    status = {4'(cnt_q), fe_q, ovr_q,
              cnt_q == NFULL, cnt_q != '0};
    rd_data_d = rd_data_q;
    if (rd_en) begin
      unique case (addr)
        2'd0: rd_data_d = pop ? mem_q[rp_q] : 8'h00;
        2'd1: rd_data_d = status;
        2'd2: rd_data_d = {7'b0, en_q};
        default: rd_data_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      state_q    <= S_IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      ovr_q      <= 1'b0;
      fe_q       <= 1'b0;
      en_q       <= 1'b1;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      avail_q    <= 1'b0;
    end else begin
      sync1_q    <= rx;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      cnt_q      <= cnt_d;
      ovr_q      <= ovr_d;
      fe_q       <= fe_d;
      en_q       <= en_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en;
      avail_q    <= (cnt_d != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wp_q] <= shift_q;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rx_avail = avail_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: frame-level stimulus against a queue-based
// model of the receiver's register behaviour.
module tb_uart_rx;
  localparam int D = 16;
  localparam int P = 3 + D / 2 + 9 * D;

  logic clk = 0;
  logic rst_n = 0;
  logic [1:0] addr = 0;
  logic rd_en = 0;
  logic wr_en = 0;
  logic [7:0] wr_data = 0;
  logic rx = 1;
  logic [7:0] rd_data;
  logic rd_valid;
  logic rx_avail;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] q[$];
  logic m_ovr = 0;
  logic m_fe = 0;
  logic m_en = 1;

  uart_rx #(.DIVISOR(D), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr),
    .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .wr_en(wr_en),
    .wr_data(wr_data), .rx(rx),
    .rx_avail(rx_avail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m_status();
    int n = q.size();
    return {4'(n), m_fe, m_ovr, n == 8, n != 0};
  endfunction

  task automatic m_frame(input logic [7:0] b,
                         input bit ok);
    if (!m_en) return;
    if (!ok) m_fe = 1;
    else if (q.size() < 8) q.push_back(b);
    else m_ovr = 1;
  endtask

  task automatic send(input logic [7:0] b,
                      input int stop_len,
                      input logic stop_v);
    rx = 0;
    repeat (D) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (D) @(posedge clk);
      #1;
    end
    rx = stop_v;
    repeat (stop_len) @(posedge clk);
    #1;
    rx = 1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [7:0] b);
    send(b, D, 1'b1);
    m_frame(b, 1);
  endtask

  task automatic reg_read(input logic [1:0] a,
                          output logic [7:0] d);
    addr = a;
    rd_en = 1;
    @(posedge clk);
    #1;
    rd_en = 0;
    d = rd_data;
    chk("rd_valid_hi", rd_valid, 1);
    @(posedge clk);
    #1;
    chk("rd_valid_lo", rd_valid, 0);
  endtask

  task automatic rd_chk(input string tag,
                        input logic [1:0] a);
    logic [7:0] exp, got;
    case (a)
      2'd0: exp = q.size() ? q.pop_front() : 8'h00;
      2'd1: exp = m_status();
      2'd2: exp = {7'b0, m_en};
      default: exp = 8'h00;
    endcase
    reg_read(a, got);
    chk(tag, got, exp);
  endtask

  task automatic reg_write(input logic [1:0] a,
                           input logic [7:0] d);
    addr = a;
    wr_data = d;
    wr_en = 1;
    @(posedge clk);
    #1;
    wr_en = 0;
    if (a == 2'd1) begin
      if (d[2]) m_ovr = 0;
      if (d[3]) m_fe = 0;
    end
    if (a == 2'd2) m_en = d[0];
  endtask

  initial begin
    #5ms;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp, v;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rx_avail", rx_avail, 0);
    rd_chk("rst_status", 1);
    rd_chk("rst_ctrl", 2);

    frame(8'hA5);
    chk("single_avail", rx_avail, 1);
    chk("single_status_lit", m_status(), 8'h11);
    rd_chk("single_status", 1);
    rd_chk("single_data", 0);
    rd_chk("single_status2", 1);

    for (int i = 1; i <= 8; i++) frame(8'(i));
    rd_chk("full_status", 1);
    frame(8'h09);
    rd_chk("ovr_status", 1);
    for (int i = 0; i < 9; i++) rd_chk("drain", 0);
    reg_write(1, 8'h04);
    rd_chk("ovr_clear", 1);

    send(8'h3C, 3 * D, 1'b0);
    m_frame(8'h3C, 0);
    rd_chk("fe_status", 1);
    frame(8'h42);
    rd_chk("fe_next_status", 1);
    rd_chk("fe_next_data", 0);
    reg_write(1, 8'h08);
    rd_chk("fe_clear", 1);

    rx = 0;
    repeat (D / 4) @(posedge clk);
    #1;
    rx = 1;
    repeat (2 * D) @(posedge clk);
    #1;
    rd_chk("glitch_status", 1);

    for (int i = 0; i < 8; i++) frame(8'($urandom_range(0, 255)));
    chk("coll_pre", q.size(), 8);
    fork
      send(8'h77, D, 1'b1);
      begin
        repeat (P - 1) @(posedge clk);
        #1;
        addr = 0;
        rd_en = 1;
        @(posedge clk);
        #1;
        rd_en = 0;
        exp = q.pop_front();
        q.push_back(8'h77);
        chk("coll_valid", rd_valid, 1);
        chk("coll_data", rd_data, exp);
      end
    join
    rd_chk("coll_status", 1);
    for (int i = 0; i < 8; i++) rd_chk("coll_drain", 0);
    rd_chk("coll_empty", 1);

    for (int i = 0; i < 3; i++) frame(8'($urandom_range(0, 255)));
    rd_chk("pre_rst_status", 1);
    fork
      send(8'hFF, D, 1'b1);
      begin
        repeat (4 * D) @(posedge clk);
        #1;
        rst_n = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
      end
    join
    q.delete();
    m_ovr = 0;
    m_fe = 0;
    m_en = 1;
    chk("mrst_rd_data", rd_data, 0);
    chk("mrst_avail", rx_avail, 0);
    rd_chk("mrst_status", 1);
    rd_chk("mrst_ctrl", 2);
    frame(8'h5A);
    rd_chk("mrst_data", 0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 7))
        0, 1: frame(8'($urandom_range(0, 255)));
        2: rd_chk("rnd_data", 0);
        3: rd_chk("rnd_status", 1);
        4: rd_chk("rnd_misc", 2'($urandom_range(2, 3)));
        5: begin
          v = 8'($urandom_range(0, 255));
          send(v, D, 1'b0);
          m_frame(v, 0);
        end
        6: reg_write(1, 8'($urandom_range(0, 255)));
        default: begin
          v = 8'($urandom_range(0, 255));
          reg_write(2'($urandom_range(0, 3)), v);
          if ($urandom_range(0, 1)) reg_write(2, 8'h01);
        end
      endcase
      chk("rnd_avail", rx_avail, q.size() != 0);
    end
    rd_chk("end_status", 1);
    while (q.size() != 0) rd_chk("end_drain", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

Memory-mapped UART receiver peripheral on the CPU data bus, decoded in the same 4 KiB window scheme as the other peripherals. It deserialises 8N1 frames from the `rx` pin into an 8-entry receive FIFO. The CPU drains the FIFO and polls status through the standard `rd_en`/`rd_valid`/`wr_en` peripheral handshake.

## Interface
- `DIVISOR`, 104: clock cycles per bit (12 MHz / 115200); must be ≥ 4.
- `DEPTH`, 8: FIFO entries; power of two.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `addr`  in  2  register select.
- `rd_en`  in  1  bus read strobe, one cycle.
- `rd_data`  out  8  read data, registered.
- `rd_valid`  out  1  high one cycle, the cycle after `rd_en`.
- `wr_en`  in  1  bus write strobe, one cycle.
- `wr_data`  in  8  write data.
- `rx`  in  1  asynchronous serial input; idle high.
- `rx_avail`  out  1  FIFO non-empty, registered.

## Operation
- Register map:
  - addr 0 DATA (R): returns the FIFO head and pops it. If the FIFO is empty, returns 0x00 with no pop. Writes are ignored.
  - addr 1 STATUS (R/W1C): bit0 not-empty, bit1 full, bit2 overrun (sticky), bit3 framing error (sticky), bits7:4 count (0..DEPTH). Writing 1 to bit2 or bit3 clears that bit; other bits are ignored on write.
  - addr 2 CTRL (R/W): bit0 enable, reset value 1. Bits 7:1 read 0.
  - addr 3: reads 0x00; writes ignored.
- `rx` passes through a 2-flop synchroniser. Both flops reset to 1.
- Receive FSM:
  - IDLE: if enable and the synced rx is 0, load the counter with DIVISOR/2−1 and go to START.
  - START: when the counter reaches 0, sample rx. If rx=0, load DIVISOR−1, set bit index 0, go to DATA. If rx=1 (glitch), go to IDLE.
  - DATA: each counter expiry, shift the sample into the MSB (bits arrive LSB first) and reload. After the 8th sample, go to STOP.
  - STOP: at counter expiry, sample rx.
    - If 1: push the byte. If the FIFO is full, drop the byte and set overrun. Go to IDLE.
    - If 0: discard the byte, set framing error, go to BREAK.
  - BREAK: wait for synced rx=1, then go to IDLE.
- Clearing enable forces IDLE on the next cycle and aborts any partial frame. FIFO contents are kept.
- FIFO: read and write pointers plus a count.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - When full, a pop and push in the same cycle both succeed and overrun is not set (pop is evaluated first).
- Reset clears the FSM to IDLE, empties the FIFO, clears both sticky flags and sets enable=1. This includes reset mid-frame.

## Timing
- Reset values: `rd_data`=0x00, `rd_valid`=0, `rx_avail`=0.
- Reads:
  - `rd_en` at cycle N gives `rd_data` and `rd_valid`=1 at N+1; `rd_valid` returns to 0 at N+2 unless `rd_en` was also high at N+1.
  - A DATA pop takes effect at N+1, so STATUS read at N+1 reflects it.
  - Back-to-back reads on consecutive cycles pop consecutive entries.
- Writes take effect at the next clock edge. `rd_en` and `wr_en` are never asserted together.
- Receive timing:
  - From the first synced-low cycle of the start bit, the byte is pushed DIVISOR/2 + 9·DIVISOR cycles later.
  - Add 2 cycles of synchroniser delay from the `rx` pin.
  - `rx_avail` and STATUS reflect the push on the following cycle.
- A STATUS W1C write and a same-cycle event setting that flag: the set wins.

## Test plan
- **Single byte:** bench DIVISOR=16, send 0xA5 as 8N1 with stop=1 → `rx_avail` rises; STATUS reads 0x11; DATA reads 0xA5 with `rd_valid` one cycle after `rd_en`; STATUS then reads 0x00.
- **Full and overrun:** send 9 bytes 0x01..0x09 without reading → after 8, STATUS=0x83. After the 9th, STATUS=0x87. Reads return 0x01..0x08, then 0x00. Writing 0x04 to STATUS clears overrun → STATUS=0x00.
- **Framing error:** send 0x3C with the stop bit held 0 for 3 bit times → no push; STATUS=0x08. A following 0x42 frame is received correctly once rx returns high.
- **Glitch rejection:** pulse rx low for DIVISOR/4 cycles → FSM returns to IDLE; no push; no error flag.
- **Pop/push collision:** FIFO full, issue a DATA read in the same cycle as a stop-bit sample of 0x77 → count stays 8; overrun stays 0; 0x77 is last out.
- **Reset mid-frame:** assert `rst_n`=0 for 1 cycle during the DATA state with 3 bytes buffered → STATUS=0x00, CTRL=0x01, `rd_data`=0x00, and the next complete frame is received normally.
